// File: rtl/cmd_queue_pkg.sv
// Shared definitions for the command queue: command width, release-FSM
// state encoding and a width helper used for counters and pointers.
package cmd_queue_pkg;

  localparam int unsigned CMD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } q_state_t;

  // Bits needed to address/count v distinct values, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command store: DEPTH entries, write/read pointers and an
// occupancy count. Flush clears pointers and count but leaves the storage
// contents untouched; only reset zeroes the storage.
module cmd_fifo
  import cmd_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [CMD_W-1:0] wdata_i,
  output logic [CMD_W-1:0] rdata_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Command storage; a flush never writes, so an abort cannot sneak a word in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_queue.sv
// Command scheduler between the UART command wrapper and the command
// processor: buffers route commands in arrival order and releases them one
// at a time, with a programmable quiet gap after each release. Abort
// flushes everything pending.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned GAP_CYC = 1024,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             cmd_in_vld,
  output logic             clr_cmd_in,
  output logic [CMD_W-1:0] cmd_out,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             abort,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam int unsigned GAP_W    = clog2_min1(GAP_CYC + 1);
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  q_state_t   state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic       rdy_q, rdy_d;
  logic       accept;
  logic       pop;

  // Accept is deliberately combinational so the wrapper sees its clear in
  // the same cycle; full is the registered flag, so a same-cycle pop never
  // frees a slot early.
  assign accept     = cmd_in_vld & ~full & ~abort & ~rst;
  assign clr_cmd_in = accept;

  // A pop only counts while cmd_out is advertised valid.
  assign pop = rdy_q & clr_cmd_rdy & ~abort;

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .flush_i (abort),
    .wdata_i (cmd_in),
    .rdata_o (cmd_out),
    .cnt_o   (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  // Release FSM and quiet-gap counter; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (abort) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) state_d = PRESENT;
        end
        PRESENT: begin
          if (pop) begin
            if (GAP_CYC == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_W'(GAP_LOAD);
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_d = (!empty || accept) ? PRESENT : IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // cmd_rdy rises one cycle after PRESENT is entered (cmd_out has settled)
  // and drops on the same edge that leaves PRESENT (pop or abort).
  always_comb begin
    rdy_d = (state_q == PRESENT) && (state_d == PRESENT);
  end

  // State, gap counter and ready flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_rdy = rdy_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed bench for cmd_queue (DEPTH 4, GAP_CYC 8).
module tb_cmd_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd_in = '0;
  logic        cmd_in_vld = 1'b0;
  logic        clr_cmd_in;
  logic [15:0] cmd_out;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  cnt;
  logic        full;
  logic        empty;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int max_cnt = 0;
  int rise_cyc = 0;
  int pop_cyc  = 0;
  int p;

  cmd_queue #(
    .DEPTH   (4),
    .GAP_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_in      (cmd_in),
    .cmd_in_vld  (cmd_in_vld),
    .clr_cmd_in  (clr_cmd_in),
    .cmd_out     (cmd_out),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .abort       (abort),
    .cnt         (cnt),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (int'(cnt) > max_cnt) max_cnt <= int'(cnt);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp, input int dly);
    int t;
    t = 0;
    while (!cmd_rdy && t < 60) begin
      tick();
      t++;
    end
    rise_cyc = cyc;
    check({tag, "_rdy"}, cmd_rdy, 1);
    check({tag, "_data"}, cmd_out, exp);
    repeat (dly) tick();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    pop_cyc = cyc;
    check({tag, "_low"}, cmd_rdy, 0);
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_cnt_in", cnt, 0);
    check("rst_clr_in", clr_cmd_in, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_cmd_out", cmd_out, 0);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_clr", clr_cmd_in, 0);
    check("rst_cnt", cnt, 0);

    // Single command
    tick();
    cmd_in = 16'h00B4; cmd_in_vld = 1'b1;
    #1;
    check("single_clr", clr_cmd_in, 1);
    tick();
    cmd_in_vld = 1'b0;
    #1;
    check("single_clr_pulse", clr_cmd_in, 0);
    check("single_cnt1", cnt, 1);
    check("single_rdy_e0", cmd_rdy, 0);
    tick();
    check("single_rdy_e1", cmd_rdy, 0);
    tick();
    check("single_rdy_e2", cmd_rdy, 1);
    check("single_data", cmd_out, 16'h00B4);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    check("single_cnt0", cnt, 0);
    check("single_rdy_low", cmd_rdy, 0);
    check("single_empty", empty, 1);
    repeat (12) tick();

    // Ordering and gap
    cmd_in = 16'h0001; cmd_in_vld = 1'b1;
    #1; check("ord_clr1", clr_cmd_in, 1);
    tick(); cmd_in = 16'h0002;
    #1; check("ord_clr2", clr_cmd_in, 1);
    tick(); cmd_in = 16'h0003;
    #1; check("ord_clr3", clr_cmd_in, 1);
    tick(); cmd_in_vld = 1'b0;
    check("ord_cnt3", cnt, 3);
    pop_expect("ord0", 16'h0001, 0);
    p = pop_cyc;
    pop_expect("ord1", 16'h0002, 0);
    check("ord_gap1", rise_cyc - p, 9);
    p = pop_cyc;
    pop_expect("ord2", 16'h0003, 0);
    check("ord_gap2", rise_cyc - p, 9);
    repeat (12) tick();

    // Full back-pressure
    cmd_in = 16'h0041; cmd_in_vld = 1'b1;
    tick(); cmd_in = 16'h0042;
    tick(); cmd_in = 16'h0043;
    tick(); cmd_in = 16'h0044;
    tick(); cmd_in = 16'h0005;
    #1;
    check("full_flag", full, 1);
    check("full_cnt", cnt, 4);
    check("full_clr_low", clr_cmd_in, 0);
    tick(); tick();
    check("full_clr_hold", clr_cmd_in, 0);
    check("full_head_rdy", cmd_rdy, 1);
    check("full_head", cmd_out, 16'h0041);
    clr_cmd_rdy = 1'b1;
    #1;
    check("full_clr_popcyc", clr_cmd_in, 0);
    tick();
    clr_cmd_rdy = 1'b0;
    #1;
    check("full_deassert", full, 0);
    check("full_clr_after_pop", clr_cmd_in, 1);
    tick();
    cmd_in_vld = 1'b0;
    #1;
    check("full_refill_cnt", cnt, 4);
    check("full_refill_flag", full, 1);
    pop_expect("full_d1", 16'h0042, 0);
    pop_expect("full_d2", 16'h0043, 0);
    pop_expect("full_d3", 16'h0044, 0);
    pop_expect("full_d4", 16'h0005, 0);
    repeat (12) tick();

    // Wrap-around with random spacing
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int g;
          int t;
          g = $urandom_range(0, 3);
          t = 0;
          repeat (g) tick();
          cmd_in = 16'h0010 + 16'(i);
          cmd_in_vld = 1'b1;
          #1;
          while (!clr_cmd_in && t < 200) begin
            tick();
            t++;
          end
          check("wrap_acc", clr_cmd_in, 1);
          tick();
          cmd_in_vld = 1'b0;
        end
      end
      begin
        for (int j = 0; j < 10; j++) pop_expect("wrap", 16'h0010 + 16'(j), int'($urandom_range(0, 3)));
      end
    join
    check("wrap_cnt_max_le4", (max_cnt <= 4), 1);
    check("wrap_empty", empty, 1);
    repeat (12) tick();

    // Abort
    cmd_in = 16'h0031; cmd_in_vld = 1'b1;
    tick(); cmd_in = 16'h0032;
    tick(); cmd_in = 16'h0033;
    tick(); cmd_in = 16'h0099;
    check("abort_pre_rdy", cmd_rdy, 1);
    check("abort_pre_cnt", cnt, 3);
    clr_cmd_rdy = 1'b1; abort = 1'b1;
    #1;
    check("abort_no_accept", clr_cmd_in, 0);
    tick();
    abort = 1'b0; clr_cmd_rdy = 1'b0; cmd_in_vld = 1'b0;
    #1;
    check("abort_empty", empty, 1);
    check("abort_rdy", cmd_rdy, 0);
    check("abort_cnt", cnt, 0);
    tick();
    cmd_in = 16'h00A5; cmd_in_vld = 1'b1;
    #1;
    check("abort_push_clr", clr_cmd_in, 1);
    tick();
    cmd_in_vld = 1'b0;
    tick();
    check("abort_push_e1", cmd_rdy, 0);
    tick();
    check("abort_push_e2", cmd_rdy, 1);
    check("abort_push_data", cmd_out, 16'h00A5);
    pop_expect("abort_pop", 16'h00A5, 0);
    repeat (12) tick();

    // Reset mid-operation during GAP
    cmd_in = 16'h0061; cmd_in_vld = 1'b1;
    tick(); cmd_in = 16'h0062;
    tick(); cmd_in = 16'h0063;
    tick(); cmd_in_vld = 1'b0;
    pop_expect("rst_pre", 16'h0061, 0);
    tick();
    check("rst_pre_cnt", cnt, 2);
    #2;
    cmd_in = 16'h0077; cmd_in_vld = 1'b1; rst = 1'b1;
    #1;
    check("rst_async_rdy", cmd_rdy, 0);
    check("rst_async_cnt", cnt, 0);
    check("rst_async_full", full, 0);
    check("rst_async_empty", empty, 1);
    check("rst_async_out", cmd_out, 0);
    check("rst_async_clr", clr_cmd_in, 0);
    tick();
    check("rst_hold_clr", clr_cmd_in, 0);
    rst = 1'b0;
    #1;
    check("rst_release_clr", clr_cmd_in, 1);
    tick();
    cmd_in_vld = 1'b0;
    #1;
    check("rst_release_cnt", cnt, 1);
    tick();
    check("rst_release_e1", cmd_rdy, 0);
    tick();
    check("rst_release_e2", cmd_rdy, 1);
    check("rst_release_data", cmd_out, 16'h0077);
    pop_expect("rst_pop", 16'h0077, 0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
